// File: rtl/uart_ctrl_if.sv
// CPU peripheral-bus view of uart_ctrl: select, strobes, word address, data and interrupt.
interface uart_ctrl_if;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output cs, rd, wr, addr, wdata, input rdata, irq);
    modport slave  (input cs, rd, wr, addr, wdata, output rdata, irq);
endinterface

// File: rtl/uart_ctrl.sv
// Memory-mapped 8N1 UART: RX/TX serialisers, CON/STAT register and level interrupt.
// Define UART_RX_FIFO_EN to replace the RX holding register with an RX_FIFO_DEPTH FIFO.
module uart_ctrl #(
    parameter int CLKS_PER_BIT  = 10417,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic        sysclk,
    input  logic        Reset_n,
    uart_ctrl_if.slave  bus,
    input  logic        uart_rx,
    output logic        uart_tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic wr_txd_s, rd_rxd_s, wr_con_s;
    logic rx_meta_r, rx_sync_r, rx_prev_r;
    rx_state_t rx_state_r, rx_state_n;
    logic [CW-1:0] rx_cnt_r, rx_cnt_n;
    logic [2:0] rx_bit_r, rx_bit_n;
    logic [7:0] rx_shift_r, rx_shift_n;
    logic rx_done_s, rx_ferr_s;
    tx_state_t tx_state_r, tx_state_n;
    logic [CW-1:0] tx_cnt_r, tx_cnt_n;
    logic [2:0] tx_bit_r, tx_bit_n;
    logic [7:0] tx_byte_r, tx_byte_n;
    logic tx_out_r, tx_out_n, tx_done_set_s, tx_busy_s;
    logic ien_rx_r, ien_tx_r, tx_done_r, overrun_r, frame_err_r, irq_r;
    logic rx_ready_s, overrun_set_s;
    logic [7:0] rx_head_s;
    logic [2:0] occ_s;
    logic [31:0] rdata_s;
    logic unused_s;

    assign wr_txd_s = bus.cs & bus.wr & (bus.addr == 2'd0);
    assign rd_rxd_s = bus.cs & bus.rd & (bus.addr == 2'd1);
    assign wr_con_s = bus.cs & bus.wr & (bus.addr == 2'd2);
    assign unused_s = &{1'b0, bus.wdata[31:8], bus.wdata[4], bus.wdata[2]};

    // Two-flop synchroniser plus one delayed copy for start-edge detection.
    always_ff @(posedge sysclk or negedge Reset_n) begin
        if (!Reset_n) begin
            {rx_meta_r, rx_sync_r, rx_prev_r} <= 3'b111;
        end else begin
            {rx_meta_r, rx_sync_r, rx_prev_r} <= {uart_rx, rx_meta_r, rx_sync_r};
        end
    end

    // RX next-state: half-bit qualify of the start bit, then whole-bit sampling.
    always_comb begin
        rx_state_n = rx_state_r;
        rx_cnt_n   = rx_cnt_r;
        rx_bit_n   = rx_bit_r;
        rx_shift_n = rx_shift_r;
        rx_done_s  = 1'b0;
        rx_ferr_s  = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                rx_cnt_n = CNT_ZERO;
                if (rx_prev_r & ~rx_sync_r) begin
                    rx_state_n = RX_START;
                end else begin
                    rx_state_n = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r == HALF_LAST) begin
                    rx_cnt_n   = CNT_ZERO;
                    rx_bit_n   = 3'd0;
                    rx_state_n = rx_sync_r ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt_r + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_n   = CNT_ZERO;
                    rx_shift_n = {rx_sync_r, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) begin
                        rx_state_n = RX_STOP;
                    end else begin
                        rx_bit_n = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt_r + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_n   = CNT_ZERO;
                    rx_state_n = RX_IDLE;
                    rx_done_s  = rx_sync_r;
                    rx_ferr_s  = ~rx_sync_r;
                end else begin
                    rx_cnt_n = rx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                rx_state_n = RX_IDLE;
                rx_cnt_n   = CNT_ZERO;
            end
        endcase
    end

    // TX next-state: the start bit is driven on the same edge that accepts the write.
    always_comb begin
        tx_state_n    = tx_state_r;
        tx_cnt_n      = tx_cnt_r;
        tx_bit_n      = tx_bit_r;
        tx_byte_n     = tx_byte_r;
        tx_out_n      = tx_out_r;
        tx_done_set_s = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                tx_cnt_n = CNT_ZERO;
                if (wr_txd_s) begin
                    tx_byte_n  = bus.wdata[7:0];
                    tx_state_n = TX_START;
                    tx_out_n   = 1'b0;
                end else begin
                    tx_out_n = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_n   = CNT_ZERO;
                    tx_bit_n   = 3'd0;
                    tx_state_n = TX_DATA;
                    tx_out_n   = tx_byte_r[0];
                end else begin
                    tx_cnt_n = tx_cnt_r + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_n = CNT_ZERO;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_n = TX_STOP;
                        tx_out_n   = 1'b1;
                    end else begin
                        tx_bit_n = tx_bit_r + 3'd1;
                        tx_out_n = tx_byte_r[tx_bit_r + 3'd1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt_r + CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_n      = CNT_ZERO;
                    tx_state_n    = TX_IDLE;
                    tx_done_set_s = 1'b1;
                end else begin
                    tx_cnt_n = tx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
                tx_cnt_n   = CNT_ZERO;
                tx_out_n   = 1'b1;
            end
        endcase
    end

    // RX and TX state registers.
    always_ff @(posedge sysclk or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= CNT_ZERO;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'd0;
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= CNT_ZERO;
            tx_bit_r   <= 3'd0;
            tx_byte_r  <= 8'd0;
            tx_out_r   <= 1'b1;
        end else begin
            rx_state_r <= rx_state_n;
            rx_cnt_r   <= rx_cnt_n;
            rx_bit_r   <= rx_bit_n;
            rx_shift_r <= rx_shift_n;
            tx_state_r <= tx_state_n;
            tx_cnt_r   <= tx_cnt_n;
            tx_bit_r   <= tx_bit_n;
            tx_byte_r  <= tx_byte_n;
            tx_out_r   <= tx_out_n;
        end
    end

    assign tx_busy_s = (tx_state_r != TX_IDLE);

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    localparam logic [AW:0] FIFO_FULL = RX_FIFO_DEPTH[AW:0];
    logic [7:0]  fifo_mem_r [RX_FIFO_DEPTH];
    logic [AW-1:0] fifo_wptr_r, fifo_rptr_r;
    logic [AW:0] fifo_cnt_r;
    logic fifo_full_s, fifo_push_s, fifo_pop_s;

    assign fifo_full_s   = (fifo_cnt_r == FIFO_FULL);
    assign fifo_pop_s    = rd_rxd_s & (fifo_cnt_r != {(AW+1){1'b0}});
    assign fifo_push_s   = rx_done_s & (~fifo_full_s | fifo_pop_s);
    assign overrun_set_s = rx_done_s & fifo_full_s & ~fifo_pop_s;
    assign rx_ready_s    = (fifo_cnt_r != {(AW+1){1'b0}});
    assign rx_head_s     = fifo_mem_r[fifo_rptr_r];
    assign occ_s         = 3'(fifo_cnt_r);

    // RX FIFO; when full, the slot being written is the head being popped this cycle.
    always_ff @(posedge sysclk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) fifo_mem_r[i] <= 8'd0;
            fifo_wptr_r <= {AW{1'b0}};
            fifo_rptr_r <= {AW{1'b0}};
            fifo_cnt_r  <= {(AW+1){1'b0}};
        end else begin
            if (fifo_push_s) begin
                fifo_mem_r[fifo_wptr_r] <= rx_shift_r;
                fifo_wptr_r <= fifo_wptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (fifo_pop_s) fifo_rptr_r <= fifo_rptr_r + {{(AW-1){1'b0}}, 1'b1};
            case ({fifo_push_s, fifo_pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + {{AW{1'b0}}, 1'b1};
                2'b01:   fifo_cnt_r <= fifo_cnt_r - {{AW{1'b0}}, 1'b1};
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end
`else
    logic [7:0] rx_data_r;
    logic       rx_ready_r;

    assign overrun_set_s = rx_done_s & rx_ready_r & ~rd_rxd_s;
    assign rx_ready_s    = rx_ready_r;
    assign rx_head_s     = rx_data_r;
    assign occ_s         = 3'd0;

    // Single holding register; a same-cycle RXD read makes room for the new byte.
    always_ff @(posedge sysclk or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_data_r  <= 8'd0;
            rx_ready_r <= 1'b0;
        end else if (rx_done_s && (!rx_ready_r || rd_rxd_s)) begin
            rx_data_r  <= rx_shift_r;
            rx_ready_r <= 1'b1;
        end else if (rd_rxd_s) begin
            rx_ready_r <= 1'b0;
        end
    end
`endif

    // Control/status flags: W1C clears lose to a same-cycle set; irq is registered.
    always_ff @(posedge sysclk or negedge Reset_n) begin
        if (!Reset_n) begin
            ien_rx_r    <= 1'b0;
            ien_tx_r    <= 1'b0;
            tx_done_r   <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
            irq_r       <= 1'b0;
        end else begin
            if (wr_con_s) {ien_tx_r, ien_rx_r} <= bus.wdata[1:0];
            tx_done_r   <= tx_done_set_s | (tx_done_r   & ~(wr_con_s & bus.wdata[3]));
            overrun_r   <= overrun_set_s | (overrun_r   & ~(wr_con_s & bus.wdata[5]));
            frame_err_r <= rx_ferr_s     | (frame_err_r & ~(wr_con_s & bus.wdata[6]));
            irq_r       <= (ien_rx_r & rx_ready_s) | (ien_tx_r & tx_done_r);
        end
    end

    // Read mux, decoded from addr alone.
    always_comb begin
        rdata_s = 32'd0;
        case (bus.addr)
            2'd1:    rdata_s = {24'd0, rx_head_s};
            2'd2:    rdata_s = {21'd0, occ_s, 1'b0, frame_err_r, overrun_r, tx_busy_s,
                                tx_done_r, rx_ready_s, ien_tx_r, ien_rx_r};
            default: rdata_s = 32'd0;
        endcase
    end

    assign bus.rdata = rdata_s;
    assign bus.irq   = irq_r;
    assign uart_tx   = tx_out_r;
endmodule

// File: tb/tb_uart_ctrl.sv
// Randomised self-checking bench for uart_ctrl with a queue-based reference model.
module tb_uart_ctrl;
    localparam int CPB = 16;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic sysclk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_drive = 1'b1;
    logic loop_en = 1'b0;
    logic uart_rx_w, uart_tx_w;
    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q_exp[$];
    logic [7:0] m_last = 8'd0;
    logic [1:0] m_ien = 2'd0;
    logic m_txdone = 1'b0, m_overrun = 1'b0, m_ferr = 1'b0;

    uart_ctrl_if bus_if ();

    uart_ctrl #(.CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(4)) dut (
        .sysclk (sysclk),
        .Reset_n(rst_n),
        .bus    (bus_if),
        .uart_rx(uart_rx_w),
        .uart_tx(uart_tx_w)
    );

    assign uart_rx_w = loop_en ? uart_tx_w : rx_drive;
    always #5 sysclk = ~sysclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge sysclk);
        bus_if.cs = 1'b1; bus_if.wr = 1'b1; bus_if.addr = a; bus_if.wdata = d;
        @(negedge sysclk);
        bus_if.cs = 1'b0; bus_if.wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge sysclk);
        bus_if.cs = 1'b1; bus_if.rd = 1'b1; bus_if.addr = a;
        #1 d = bus_if.rdata;
        @(negedge sysclk);
        bus_if.cs = 1'b0; bus_if.rd = 1'b0;
    endtask

    task automatic con_wr(input logic [31:0] d);
        bus_wr(2'd2, d);
        m_ien = d[1:0];
        if (d[3]) m_txdone = 1'b0;
        if (d[5]) m_overrun = 1'b0;
        if (d[6]) m_ferr = 1'b0;
    endtask

    task automatic model_deliver(input logic [7:0] b);
        if (q_exp.size() < CAP) q_exp.push_back(b);
        else m_overrun = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drive = bits[i];
            tick(CPB);
        end
        rx_drive = 1'b1;
        if (stop_bit) model_deliver(b);
        else m_ferr = 1'b1;
    endtask

    task automatic check_stat(input string name);
        logic [31:0] d, e;
        bus_rd(2'd2, d);
        e = 32'd0;
        e[1:0] = m_ien;
        e[2] = (q_exp.size() != 0);
        e[3] = m_txdone;
        e[5] = m_overrun;
        e[6] = m_ferr;
`ifdef UART_RX_FIFO_EN
        e[10:8] = 3'(q_exp.size());
`endif
        vectors++;
        if (d !== e) begin
            miscompares++;
            $display("FAIL %s stat: got %h expected %h", name, d, e);
        end
    endtask

    task automatic check_rxd(input string name);
        logic [31:0] d;
        bus_rd(2'd1, d);
        if (q_exp.size() != 0) m_last = q_exp.pop_front();
        vectors++;
        if (d !== {24'd0, m_last}) begin
            miscompares++;
            $display("FAIL %s rxd: got %h expected %h", name, d, {24'd0, m_last});
        end
    endtask

    task automatic check_irq(input string name);
        logic e;
        e = (m_ien[0] && q_exp.size() != 0) || (m_ien[1] && m_txdone);
        vectors++;
        if (bus_if.irq !== e) begin
            miscompares++;
            $display("FAIL %s irq: got %b expected %b", name, bus_if.irq, e);
        end
    endtask

    // Sends one byte and checks every sample of the line against the 8N1 frame.
    task automatic tx_frame(input logic [7:0] b, input logic inject);
        logic [9:0] exp;
        int bad, busy_bad, tail_bad;
        exp = {1'b1, b, 1'b0};
        bad = 0; busy_bad = 0; tail_bad = 0;
        bus_wr(2'd0, {24'd0, b});
        bus_if.addr = 2'd2;
        for (int s = 0; s < 10 * CPB; s++) begin
            if (uart_tx_w !== exp[s / CPB]) bad++;
            if ((s % CPB) == 8 && bus_if.rdata[4] !== 1'b1) busy_bad++;
            if (inject && s == 80) begin
                bus_if.cs = 1'b1; bus_if.wr = 1'b1; bus_if.addr = 2'd0; bus_if.wdata = 32'h3C;
            end
            if (inject && s == 81) begin
                bus_if.cs = 1'b0; bus_if.wr = 1'b0; bus_if.addr = 2'd2;
            end
            if ((s % CPB) == CPB - 1) begin
                vectors++;
                if (bad != 0) begin
                    miscompares++;
                    $display("FAIL tx_bit%0d of %h: %0d samples wrong, required level %b",
                             s / CPB, b, bad, exp[s / CPB]);
                end
                bad = 0;
            end
            @(negedge sysclk);
        end
        m_txdone = 1'b1;
        vectors++;
        if (busy_bad != 0) begin
            miscompares++;
            $display("FAIL tx_busy: %0d samples low, required 1", busy_bad);
        end
        for (int s = 0; s < 40; s++) begin
            if (uart_tx_w !== 1'b1) tail_bad++;
            @(negedge sysclk);
        end
        vectors++;
        if (tail_bad != 0) begin
            miscompares++;
            $display("FAIL tx_idle_after: %0d low samples, required 0", tail_bad);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bus_if.cs = 1'b0; bus_if.rd = 1'b0; bus_if.wr = 1'b0;
        bus_if.addr = 2'd2; bus_if.wdata = 32'd0;
        tick(3);
        vectors++;
        if (uart_tx_w !== 1'b1 || bus_if.irq !== 1'b0 || bus_if.rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: tx=%b irq=%b stat=%h required 1 0 0",
                     uart_tx_w, bus_if.irq, bus_if.rdata);
        end
        @(negedge sysclk) rst_n = 1'b1;
        bus_rd(2'd1, d);
        vectors++;
        if (d !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_rxd: got %h required 0", d);
        end
        check_stat("reset");
    endtask

    task automatic test_rx_basic();
        send_frame(8'h0C, 1'b1);
        check_stat("rx_0c_ready");
        check_rxd("rx_0c");
        check_stat("rx_0c_cleared");
    endtask

    task automatic test_tx();
        tx_frame(8'hA5, 1'b1);
        check_stat("tx_a5_done");
    endtask

    task automatic test_irq();
        logic [9:0] bits;
        logic irq_hist[24];
        logic rdy_hist[24];
        int first;
        con_wr(32'h0B);
        tick(2);
        check_irq("irq_idle");
        bits = {1'b1, 8'h41, 1'b0};
        for (int i = 0; i < 9; i++) begin
            rx_drive = bits[i];
            tick(CPB);
        end
        rx_drive = 1'b1;
        bus_if.addr = 2'd2;
        first = -1;
        for (int s = 0; s < 24; s++) begin
            @(negedge sysclk);
            irq_hist[s] = bus_if.irq;
            rdy_hist[s] = bus_if.rdata[2];
            if (first < 0 && rdy_hist[s] === 1'b1) first = s;
        end
        model_deliver(8'h41);
        vectors++;
        if (first < 0 || first > 22) begin
            miscompares++;
            $display("FAIL irq_rdy_seen: first ready sample %0d, required 0..22", first);
        end else if (irq_hist[first] !== 1'b0 || irq_hist[first + 1] !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_latency: got %b%b required 01", irq_hist[first], irq_hist[first + 1]);
        end
        check_irq("irq_rx_level");
        check_rxd("irq_rx_41");
        tick(2);
        check_irq("irq_after_read");
        tx_frame(8'($urandom), 1'b0);
        check_irq("irq_tx_done");
        con_wr(32'h0B);
        tick(2);
        check_irq("irq_tx_cleared");
        check_stat("irq_w1c_done");
        con_wr(32'h00);
    endtask

    task automatic test_back_to_back();
        send_frame(8'h0C, 1'b1);
        send_frame(8'h08, 1'b1);
        check_stat("b2b_both");
        while (q_exp.size() != 0) begin
            check_rxd("b2b_read");
            check_stat("b2b_after_read");
        end
        check_rxd("b2b_empty_read");
        con_wr(32'h20);
        check_stat("b2b_overrun_cleared");
    endtask

    task automatic test_glitch_ferr();
        rx_drive = 1'b0;
        tick(4);
        rx_drive = 1'b1;
        tick(40);
        check_stat("glitch");
        send_frame(8'($urandom), 1'b0);
        tick(8);
        check_stat("frame_err");
        con_wr(32'h40);
        check_stat("frame_err_cleared");
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++) begin
            send_frame(8'($urandom), 1'b1);
            check_stat("rand_rx");
            check_rxd("rand_rx");
            tx_frame(8'($urandom), 1'b0);
            con_wr(32'h08);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] b;
        b = 8'($urandom);
        loop_en = 1'b1;
        bus_wr(2'd0, {24'd0, b});
        tick(10 * CPB + 20);
        model_deliver(b);
        m_txdone = 1'b1;
        check_stat("loop");
        check_rxd("loop");
        loop_en = 1'b0;
        con_wr(32'h08);
    endtask

    task automatic test_reset_mid_tx();
        bus_wr(2'd0, {24'd0, 8'($urandom)});
        bus_if.addr = 2'd2;
        tick(3 * CPB + 5);
        #2 rst_n = 1'b0;
        #1;
        q_exp.delete();
        m_last = 8'd0; m_ien = 2'd0;
        m_txdone = 1'b0; m_overrun = 1'b0; m_ferr = 1'b0;
        vectors++;
        if (uart_tx_w !== 1'b1 || bus_if.irq !== 1'b0 || bus_if.rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL midtx_reset: tx=%b irq=%b stat=%h required 1 0 0",
                     uart_tx_w, bus_if.irq, bus_if.rdata);
        end
        tick(3);
        @(negedge sysclk) rst_n = 1'b1;
        check_stat("after_reset");
        check_rxd("after_reset");
        tx_frame(8'h55, 1'b0);
        check_stat("after_reset_tx");
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_tx();
        test_irq();
        test_back_to_back();
        test_glitch_ferr();
        test_random();
        test_loopback();
        test_reset_mid_tx();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
